// File: rtl/regincr_rr_sched_pkg.sv
// Shared types for the round-robin scheduler around the registered +INCR incrementer.
// Holds the FSM state encoding and the owner/pointer index width helpers.
package regincr_rr_sched_pkg;

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  localparam int NREQ_DEFAULT = 4;
  localparam int OWN_W        = $clog2(NREQ_DEFAULT);

  // Index width for an arbitrary requester count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regincr_rr_arb.sv
// Combinational round-robin arbiter: first set bit of req searching from ptr upward, wrapping.
// Produces a one-hot grant, the granted index and an any-valid flag.
module regincr_rr_arb
  import regincr_rr_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IW   = OWN_W
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((32'(ptr) + 32'(k)) % 32'(NREQ));
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt_idx      = idx;
        gnt[idx]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regincr_rr_sched.sv
// Round-robin scheduler sharing one registered +INCR incrementer among NREQ val/rdy requesters.
// Define REGINCR_RR_SCHED_PIPE_EN to accept a new request in the same cycle a response completes.
module regincr_rr_sched
  import regincr_rr_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 9,
  parameter int INCR  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_val,
  output logic [NREQ-1:0]       req_rdy,
  input  logic [NREQ*NBITS-1:0] req_msg,
  output logic [NREQ-1:0]       resp_val,
  input  logic [NREQ-1:0]       resp_rdy,
  output logic [NBITS-1:0]      resp_msg
);

  localparam int IW = idx_width(NREQ);

  state_e         state_q, state_d;
  logic [NBITS-1:0] opnd_q, opnd_d;
  logic [IW-1:0]  own_q, own_d;
  logic [IW-1:0]  ptr_q, ptr_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            grant_en;
  logic            resp_done;

  // ptr_q already points past the current owner, so the pipelined grant needs no extra adjustment.
  regincr_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req     (req_val),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d   = state_q;
    opnd_d    = opnd_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    req_rdy   = '0;
    resp_val  = '0;
    resp_msg  = opnd_q + NBITS'(INCR);
    grant_en  = 1'b0;
    resp_done = 1'b0;

    case (state_q)
      IDLE: begin
        grant_en = 1'b1;
      end
      RESP: begin
        resp_val[own_q] = 1'b1;
        resp_done       = resp_rdy[own_q];
        if (resp_done) begin
          state_d = IDLE;
        end
`ifdef REGINCR_RR_SCHED_PIPE_EN
        grant_en = resp_done;
`else
        grant_en = 1'b0;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Gating with reset keeps req_rdy low while the block is held in reset.
    if (grant_en && arb_any && reset) begin
      req_rdy = arb_gnt;
      opnd_d  = req_msg[32'(arb_idx)*NBITS +: NBITS];
      own_d   = arb_idx;
      ptr_d   = (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
      state_d = RESP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_regincr_rr_sched.sv
// Self-checking bench for regincr_rr_sched: directed vector table, corner-case sequences
// and a randomized run against a transaction-level reference model.
module tb_regincr_rr_sched;

  localparam int NREQ  = 4;
  localparam int NBITS = 9;
  localparam int INCR  = 1;
`ifdef REGINCR_RR_SCHED_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  localparam int EXP_GAP = PIPE ? 1 : 2;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_val;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ*NBITS-1:0] req_msg;
  logic [NREQ-1:0]       resp_val;
  logic [NREQ-1:0]       resp_rdy;
  logic [NBITS-1:0]      resp_msg;

  regincr_rr_sched #(
    .NREQ  (NREQ),
    .NBITS (NBITS),
    .INCR  (INCR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the incrementer, what it holds, and where the search starts.
  int m_busy, m_own, m_opnd, m_ptr, m_gnt;

  logic [NREQ-1:0]  obs_req_rdy, obs_resp_val;
  logic [NBITS-1:0] obs_resp_msg;
  int cycle = 0;

  typedef struct {
    logic [NREQ-1:0]       rv;
    logic [NREQ*NBITS-1:0] msg;
    logic [NREQ-1:0]       rr;
    logic [NREQ-1:0]       exp_rdy;
    logic [NREQ-1:0]       exp_val;
    logic [NBITS-1:0]      exp_msg;
  } vec_t;

  vec_t vecs[18];
  int   exp_grants[5] = '{0, 1, 2, 3, 0};
  int   g_list[$];
  int   r_own[$];
  int   r_msg[$];
  int   r_cyc[$];

  function automatic logic [NREQ*NBITS-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [NREQ*NBITS-1:0] r;
    r = '0;
    r[0*NBITS +: NBITS] = NBITS'(a);
    r[1*NBITS +: NBITS] = NBITS'(b);
    r[2*NBITS +: NBITS] = NBITS'(c);
    r[3*NBITS +: NBITS] = NBITS'(d);
    return r;
  endfunction

  function automatic int firstIdx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_busy = 0;
    m_own  = 0;
    m_opnd = 0;
    m_ptr  = 0;
    m_gnt  = -1;
  endtask

  task automatic modelEval(output logic [NREQ-1:0] e_rdy, output logic [NREQ-1:0] e_val,
                           output logic [NBITS-1:0] e_msg);
    bit can;
    e_val = (m_busy != 0) ? NREQ'(1 << m_own) : '0;
    e_msg = NBITS'((m_opnd + INCR) % (1 << NBITS));
    can   = (m_busy == 0) || (PIPE && resp_rdy[m_own]);
    m_gnt = -1;
    if (can) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_gnt < 0 && req_val[(m_ptr + k) % NREQ]) m_gnt = (m_ptr + k) % NREQ;
      end
    end
    e_rdy = (m_gnt >= 0) ? NREQ'(1 << m_gnt) : '0;
  endtask

  task automatic modelUpdate();
    if (m_busy != 0 && resp_rdy[m_own]) m_busy = 0;
    if (m_gnt >= 0) begin
      m_busy = 1;
      m_own  = m_gnt;
      m_opnd = int'(req_msg[m_gnt*NBITS +: NBITS]);
      m_ptr  = (m_gnt + 1) % NREQ;
    end
  endtask

  // One clock cycle: drive, sample at the falling edge, compare with the model, advance.
  task automatic applyStimulus(input logic [NREQ-1:0] rv, input logic [NREQ*NBITS-1:0] msg,
                               input logic [NREQ-1:0] rr);
    logic [NREQ-1:0]  e_rdy, e_val;
    logic [NBITS-1:0] e_msg;
    req_val  = rv;
    req_msg  = msg;
    resp_rdy = rr;
    @(negedge clk);
    obs_req_rdy  = req_rdy;
    obs_resp_val = resp_val;
    obs_resp_msg = resp_msg;
    modelEval(e_rdy, e_val, e_msg);
    checkOutput("model req_rdy", 32'(obs_req_rdy), 32'(e_rdy));
    checkOutput("model resp_val", 32'(obs_resp_val), 32'(e_val));
    if (e_val != 0) checkOutput("model resp_msg", 32'(obs_resp_msg), 32'(e_msg));
    @(posedge clk);
    modelUpdate();
    cycle++;
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b0;
    req_val  = '1;
    resp_rdy = '1;
    req_msg  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset req_rdy", 32'(req_rdy), 32'h0);
    checkOutput("reset resp_val", 32'(resp_val), 32'h0);
    modelReset();
    req_val  = '0;
    resp_rdy = '0;
    reset    = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NBITS-1:0]      rmsg[NREQ];
    logic [NREQ-1:0]       rv;
    logic [NREQ*NBITS-1:0] pm;

    // Directed vectors; every RESP cycle with resp_rdy[own]=1 has no other requests,
    // so the expectations hold for both the base and the pipelined build.
    vecs[0]  = '{4'b0001, pack4(9'h005, 0, 0, 0),     4'b0000, 4'b0001, 4'b0000, 9'h000};
    vecs[1]  = '{4'b0000, pack4(0, 0, 0, 0),          4'b0001, 4'b0000, 4'b0001, 9'h006};
    vecs[2]  = '{4'b0100, pack4(0, 0, 9'h1FF, 0),     4'b0000, 4'b0100, 4'b0000, 9'h000};
    vecs[3]  = '{4'b0000, pack4(0, 0, 0, 0),          4'b0100, 4'b0000, 4'b0100, 9'h000};
    vecs[4]  = '{4'b0010, pack4(0, 9'h0AB, 0, 0),     4'b0000, 4'b0010, 4'b0000, 9'h000};
    vecs[5]  = '{4'b1101, pack4(9'h001, 0, 9'h002, 9'h003), 4'b1101, 4'b0000, 4'b0010, 9'h0AC};
    vecs[6]  = '{4'b1101, pack4(9'h001, 0, 9'h002, 9'h003), 4'b1101, 4'b0000, 4'b0010, 9'h0AC};
    vecs[7]  = '{4'b1101, pack4(9'h001, 0, 9'h002, 9'h003), 4'b1101, 4'b0000, 4'b0010, 9'h0AC};
    vecs[8]  = '{4'b0000, pack4(0, 0, 0, 0),          4'b0010, 4'b0000, 4'b0010, 9'h0AC};
    vecs[9]  = '{4'b0001, pack4(9'h07F, 0, 0, 0),     4'b0000, 4'b0001, 4'b0000, 9'h000};
    vecs[10] = '{4'b0000, pack4(0, 0, 0, 0),          4'b1110, 4'b0000, 4'b0001, 9'h080};
    vecs[11] = '{4'b0000, pack4(0, 0, 0, 0),          4'b1110, 4'b0000, 4'b0001, 9'h080};
    vecs[12] = '{4'b0000, pack4(0, 0, 0, 0),          4'b0001, 4'b0000, 4'b0001, 9'h080};
    vecs[13] = '{4'b0000, pack4(0, 0, 0, 0),          4'b1111, 4'b0000, 4'b0000, 9'h000};
    vecs[14] = '{4'b1001, pack4(9'h055, 0, 0, 9'h123), 4'b0000, 4'b1000, 4'b0000, 9'h000};
    vecs[15] = '{4'b0000, pack4(0, 0, 0, 0),          4'b1000, 4'b0000, 4'b1000, 9'h124};
    vecs[16] = '{4'b1001, pack4(9'h055, 0, 0, 9'h123), 4'b0000, 4'b0001, 4'b0000, 9'h000};
    vecs[17] = '{4'b0000, pack4(0, 0, 0, 0),          4'b0001, 4'b0000, 4'b0001, 9'h056};

    doReset();
    for (int v = 0; v < 18; v++) begin
      applyStimulus(vecs[v].rv, vecs[v].msg, vecs[v].rr);
      checkOutput($sformatf("vec%0d req_rdy", v), 32'(obs_req_rdy), 32'(vecs[v].exp_rdy));
      checkOutput($sformatf("vec%0d resp_val", v), 32'(obs_resp_val), 32'(vecs[v].exp_val));
      if (vecs[v].exp_val != 0)
        checkOutput($sformatf("vec%0d resp_msg", v), 32'(obs_resp_msg), 32'(vecs[v].exp_msg));
    end

    // All four requesting continuously: strict rotation and the expected response rate.
    doReset();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(4'b1111, pack4(9'h010, 9'h020, 9'h030, 9'h040), 4'b1111);
      if (obs_req_rdy != 0) g_list.push_back(firstIdx(obs_req_rdy));
      if (obs_resp_val != 0) begin
        r_own.push_back(firstIdx(obs_resp_val));
        r_msg.push_back(int'(obs_resp_msg));
        r_cyc.push_back(c);
      end
    end
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("rotation grant%0d", k), (k < g_list.size()) ? g_list[k] : 99, exp_grants[k]);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rotation resp_own%0d", k), (k < r_own.size()) ? r_own[k] : 99, k);
      checkOutput($sformatf("rotation resp_msg%0d", k), (k < r_msg.size()) ? r_msg[k] : 999,
                  32'h11 + 32'h10 * k);
    end
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("rotation gap%0d", k),
                  (k + 1 < r_cyc.size()) ? r_cyc[k+1] - r_cyc[k] : 99, EXP_GAP);

    // Asynchronous reset while a response is pending drops the transaction.
    doReset();
    applyStimulus(4'b0010, pack4(0, 9'h0AA, 0, 0), 4'b0000);
    req_val = 4'b1111;
    checkOutput("pre-reset resp_val", 32'(resp_val), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset resp_val", 32'(resp_val), 32'h0);
    checkOutput("async reset req_rdy", 32'(req_rdy), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("held reset resp_val", 32'(resp_val), 32'h0);
    modelReset();
    req_val = '0;
    reset   = 1'b1;
    applyStimulus(4'b1001, pack4(9'h011, 0, 0, 9'h033), 4'b0000);
    checkOutput("post-reset grant", 32'(obs_req_rdy), 32'h1);
    applyStimulus(4'b1000, pack4(9'h011, 0, 0, 9'h033), 4'b0001);
    checkOutput("post-reset resp_val", 32'(obs_resp_val), 32'h1);
    checkOutput("post-reset resp_msg", 32'(obs_resp_msg), 32'h012);
    applyStimulus(4'b1000, pack4(9'h011, 0, 0, 9'h033), 4'b1000);
    applyStimulus(4'b0000, pack4(0, 0, 0, 0), 4'b1111);

    // Randomized traffic; a pending requester keeps its operand until granted.
    doReset();
    for (int i = 0; i < NREQ; i++) rmsg[i] = NBITS'($urandom);
    rv = NREQ'($urandom);
    for (int c = 0; c < 400; c++) begin
      pm = '0;
      for (int i = 0; i < NREQ; i++) pm[i*NBITS +: NBITS] = rmsg[i];
      applyStimulus(rv, pm, NREQ'($urandom));
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] || obs_req_rdy[i]) begin
          rv[i]   = 1'($urandom_range(0, 1));
          rmsg[i] = ($urandom_range(0, 7) == 0) ? 9'h1FF : NBITS'($urandom);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
